// File: rtl/eth_tx_fcs_insert.sv
// Ethernet TX stage: pads short frames and appends the IEEE 802.3 FCS.
// Byte-wide stream in, byte-wide stream out, one registered output beat.
module eth_tx_fcs_insert #(
  parameter int MIN_FRAME_LEN = 60,
  parameter bit ENABLE_PAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done
);

  localparam int CW = $clog2(MIN_FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_FRAME_LEN);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    FCS
  } state_t;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

  // MSB-first CRC-32 over one byte; callers bit-reverse the data
  function automatic logic [31:0] crc32data8(
    input logic [7:0]  d,
    input logic [31:0] c
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

  state_t          state;
  logic [31:0]     crc;
  logic [CW-1:0]   cnt;
  logic [1:0]      kidx;
  logic            out_free;
  logic            take;
  logic [CW-1:0]   cnt_inc;
  logic [7:0]      fcs_byte;

  assign out_free = !m_valid || m_ready;
  assign s_ready  = !rst && out_free &&
                    (state == IDLE || state == DATA);
  assign take     = s_valid && s_ready;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  // FCS bytes go out reflected and complemented, low byte first
  always_comb begin
    fcs_byte = '0;
    unique case (kidx)
      2'd0: fcs_byte = ~rev8(crc[31:24]);
      2'd1: fcs_byte = ~rev8(crc[23:16]);
      2'd2: fcs_byte = ~rev8(crc[15:8]);
      2'd3: fcs_byte = ~rev8(crc[7:0]);
    endcase
  end

  // Frame FSM plus the single output register it feeds
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      crc        <= CRC_INIT;
      cnt        <= '0;
      kidx       <= 2'd0;
      m_data     <= 8'h00;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_valid && m_ready && m_last;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      unique case (state)
        IDLE, DATA: begin
          if (take) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc32data8(rev8(s_data), crc);
            cnt     <= cnt_inc;
            if (s_last) begin
              state <= (ENABLE_PAD && cnt_inc < CNT_MAX) ? PAD : FCS;
            end else begin
              state <= DATA;
            end
          end
        end
        PAD: begin
          if (out_free) begin
            m_data  <= 8'h00;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc32data8(8'h00, crc);
            cnt     <= cnt_inc;
            if (cnt_inc == CNT_MAX) state <= FCS;
          end
        end
        FCS: begin
          if (out_free) begin
            m_data  <= fcs_byte;
            m_valid <= 1'b1;
            m_last  <= (kidx == 2'd3);
            kidx    <= kidx + 2'd1;
            if (kidx == 2'd3) begin
              crc   <= CRC_INIT;
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
